// File: rtl/gate_truth_sequencer_pkg.sv
// Shared state encodings and sizing helper for the gate truth-table sequencer.
package gate_truth_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Width of the settle down-counter; at least one bit so SETTLE=0 still builds.
    function automatic int settle_cnt_w(input int settle);
        return (settle < 2) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/seq_settle_counter.sv
// Loadable down-counter that stops at zero; ZERO flags the end of a settle window.
module seq_settle_counter #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gate_truth_sequencer.sv
// Sweeps a gate through all input vectors and checks it against a truth table.
// Optional macro GATE_SEQ_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module gate_truth_sequencer
    import gate_truth_sequencer_pkg::*;
#(
    parameter int                    N_IN   = 2,
    parameter logic [(1<<N_IN)-1:0]  EXPECT = 4'b1000,
    parameter int                    SETTLE = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic            i_gate_y,
    output logic [N_IN-1:0] o_vec,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic [N_IN:0]   o_err_cnt,
    output logic [N_IN-1:0] o_first_fail
);

    localparam int            CW       = settle_cnt_w(SETTLE);
    localparam logic [CW-1:0] SETTLE_V = CW'(SETTLE);
    localparam logic [N_IN:0] ERR_MAX  = {1'b1, {N_IN{1'b0}}};

    state_t          r_state, w_state_nxt;
    logic [N_IN-1:0] r_vec, w_vec_nxt;
    logic [N_IN:0]   r_err, w_err_nxt;
    logic [N_IN-1:0] r_ff, w_ff_nxt;
    logic            r_pass, w_pass_nxt;
    logic            r_busy, r_done;
    logic            w_load, w_zero, w_mis;

    seq_settle_counter #(.W(CW)) u_settle (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (SETTLE_V),
        .o_zero     (w_zero)
    );

    assign w_mis = (i_gate_y != EXPECT[r_vec]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_err   <= '0;
            r_ff    <= '0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_err   <= w_err_nxt;
            r_ff    <= w_ff_nxt;
            r_pass  <= w_pass_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (w_state_nxt == ST_FIN);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_err_nxt   = r_err;
        w_ff_nxt    = r_ff;
        w_pass_nxt  = r_pass;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_state_nxt = ST_WAIT;
                    w_vec_nxt   = '0;
                    w_err_nxt   = '0;
                    w_ff_nxt    = '0;
                    w_pass_nxt  = 1'b0;
                    w_load      = 1'b1;
                end
            end
            ST_WAIT: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_vec_nxt   = '0;
                    w_pass_nxt  = 1'b0;
                end else if (w_zero) begin
                    if (w_mis) begin
                        if (r_err != ERR_MAX) w_err_nxt = r_err + 1'b1;
                        if (r_err == '0)      w_ff_nxt  = r_vec;
                    end
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
                    if (w_mis || (&r_vec)) begin
                        w_state_nxt = ST_FIN;
                    end else begin
                        w_vec_nxt = r_vec + 1'b1;
                        w_load    = 1'b1;
                    end
`else
                    if (&r_vec) begin
                        w_state_nxt = ST_FIN;
                    end else begin
                        w_vec_nxt = r_vec + 1'b1;
                        w_load    = 1'b1;
                    end
`endif
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
                if (i_abort) begin
                    w_vec_nxt  = '0;
                    w_pass_nxt = 1'b0;
                end else begin
                    w_pass_nxt = (r_err == '0);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_vec        = r_vec;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_err_cnt    = r_err;
    assign o_first_fail = r_ff;

endmodule
